mdu_unit: RTL and testbench
===========================

# mdu_unit

Multiply/divide unit for the execute stage of the pipelined CPU, sitting beside `ALU` and consuming the same forwarded E-stage operands `A1`/`A2`. It runs MIPS-style multiply, divide, move-to and move-from operations with fixed multi-cycle latency, holds the HI/LO registers, and reports `busy` so the hazard unit can stall later MDU instructions. Its `rdata` output is muxed with the ALU `ans` into the E/M pipeline register.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: cycles from start to HI/LO commit for `mult`/`multu`; must be ≥1.
- `DIV_CYCLES`, default 10: cycles from start to HI/LO commit for `div`/`divu`; must be ≥1.

Ports:
- `clk`  in  1  the single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `en`  in  1  a valid, non-stalled instruction is in the E stage; qualifies `MDU_op`.
- `MDU_op`  in  4  0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo; other codes act as none.
- `A1`  in  32  rs operand, forwarded.
- `A2`  in  32  rt operand, forwarded.
- `start`  out  1  combinational: `en` and `MDU_op` is mult/multu/div/divu.
- `busy`  out  1  registered; an operation is in flight.
- `rdata`  out  32  combinational: HI for mfhi, LO for mflo, else 0.
- `HI`  out  32  current HI register.
- `LO`  out  32  current LO register.

## Operation
- States: IDLE and RUN. A down-counter sized to hold max(`MULT_CYCLES`,`DIV_CYCLES`) tracks RUN.
- IDLE with `start`: the full 64-bit result is computed from `A1`/`A2` and latched into pending registers, the counter is loaded with MULT_CYCLES or DIV_CYCLES, and the unit enters RUN.
- RUN: the counter decrements each edge. When it reaches the final edge, the pending values are written to HI/LO and the unit returns to IDLE.
- mult: signed 32×32→64. HI = [63:32], LO = [31:0]. multu is the unsigned form.
- div: signed. LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend. divu is the unsigned form.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- Divide by zero (`A2`=0): the unit still goes busy for DIV_CYCLES, but HI/LO are left unchanged at commit.
- mthi/mtlo with `en` in IDLE: HI or LO is written from `A1` at the next edge, with no busy.
- mfhi/mflo: pure read of the current registers, with no state change.
- Any op arriving while `busy`=1 is ignored. The hazard unit must stall every MDU op (including mf/mt) while `start` or `busy` is high; this block does not queue requests.

## Timing
- Reset values: `busy`=0, HI=0, LO=0, counter=0, pending registers=0, state IDLE. Consequently `rdata`=0.
- Start sampled at edge T: `busy` is 1 from after edge T until edge T+N, where N = MULT_CYCLES or DIV_CYCLES. HI/LO update and `busy` falls at edge T+N. `busy` is therefore high for exactly N cycles.
- An mfhi/mflo in the E stage during cycle T+N sees the new value.
- No back-to-back start: a start sampled at the commit edge is ignored, because `busy` is still 1 in that cycle.
- `reset` asserted mid-operation: the operation is aborted, `busy` drops to 0 asynchronously, and HI/LO are cleared. The pending result is never committed.
- `en`=0: no state change except that an in-flight operation continues.

## Configuration
- `MDU_DIV_EN` defined: div/divu are implemented as above.
- `MDU_DIV_EN` not defined: div/divu are decoded as none. In that case `start` is not asserted for them, `busy` stays 0, HI/LO are unchanged, and no divider logic is synthesised. `DIV_CYCLES` is unused.

## Test plan
- Signed multiply: mult with A1=0xFFFFFFFF, A2=0x00000002. Expect `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- Unsigned multiply: multu with the same operands. Expect HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- Signed divide: div with A1=0xFFFFFFF9 (−7), A2=0x00000002. After 10 busy cycles expect LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned divide by zero: divu with A1=7, A2=0, starting from HI=0x11, LO=0x22. Expect `busy` for 10 cycles, then HI=0x11 and LO=0x22 unchanged.
- Move and read back: mthi with A1=0xDEADBEEF, then mfhi. Expect `rdata`=0xDEADBEEF the next cycle and `busy` to remain 0. A mult issued while `busy`=1 must leave the in-flight result unchanged.
- Reset mid-divide: assert `reset` in the 4th busy cycle of a div. Expect `busy`=0, HI=LO=0 immediately, and no commit afterwards.

Source files
------------

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage: fixed-latency mult/div with HI/LO registers.
// Define MDU_DIV_EN to implement div/divu; otherwise they decode as no-ops.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  MDU_op,
    input  logic [31:0] A1,
    input  logic [31:0] A2,
    output logic        start,
    output logic        busy,
    output logic [31:0] rdata,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_MFHI  = 4'b0101;
    localparam logic [3:0] OP_MFLO  = 4'b0110;
    localparam logic [3:0] OP_MTHI  = 4'b0111;
    localparam logic [3:0] OP_MTLO  = 4'b1000;
`ifdef MDU_DIV_EN
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
`endif

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      hi_q, lo_q, hi_nxt, lo_nxt;
    logic [31:0]      pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
    logic             pend_wr, pend_wr_nxt;
    logic             is_mul, is_div;
    logic [63:0]      mul_res, op_res;

    // Op decode
    always_comb is_mul = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU);
`ifdef MDU_DIV_EN
    always_comb is_div = (MDU_op == OP_DIV) || (MDU_op == OP_DIVU);
`else
    always_comb is_div = 1'b0;
`endif

    assign start = en && (is_mul || is_div);

    // 64-bit product; sign-extending both operands gives the signed result mod 2^64
    always_comb begin
        if (MDU_op == OP_MULT) begin
            mul_res = {{32{A1[31]}}, A1} * {{32{A2[31]}}, A2};
        end else begin
            mul_res = {32'd0, A1} * {32'd0, A2};
        end
    end

`ifdef MDU_DIV_EN
    logic        div_sgn;
    logic [31:0] dvd_mag, dvs_mag, q_mag, r_mag, quo, rem;

    // Sign-magnitude divide: avoids the 0x80000000 / -1 corner and keeps remainder sign = dividend sign
    always_comb begin
        div_sgn = (MDU_op == OP_DIV);
        dvd_mag = (div_sgn && A1[31]) ? (~A1 + 32'd1) : A1;
        if (A2 == 32'd0) begin
            dvs_mag = 32'd1;
        end else begin
            dvs_mag = (div_sgn && A2[31]) ? (~A2 + 32'd1) : A2;
        end
        q_mag = dvd_mag / dvs_mag;
        r_mag = dvd_mag % dvs_mag;
        quo   = (div_sgn && (A1[31] ^ A2[31])) ? (~q_mag + 32'd1) : q_mag;
        rem   = (div_sgn && A1[31]) ? (~r_mag + 32'd1) : r_mag;
    end

    assign op_res = is_div ? {rem, quo} : mul_res;
`else
    assign op_res = mul_res;
`endif

    // Next-state and register updates
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_wr_nxt = pend_wr;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = S_RUN;
                    pend_hi_nxt = op_res[63:32];
                    pend_lo_nxt = op_res[31:0];
                    pend_wr_nxt = !(is_div && (A2 == 32'd0));
                    cnt_nxt     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end else if (en && (MDU_op == OP_MTHI)) begin
                    hi_nxt = A1;
                end else if (en && (MDU_op == OP_MTLO)) begin
                    lo_nxt = A1;
                end
            end
            S_RUN: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    if (pend_wr) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_wr <= pend_wr_nxt;
        end
    end

    assign busy = (state == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

    // Read port for mfhi/mflo
    always_comb begin
        rdata = 32'd0;
        if (MDU_op == OP_MFHI) begin
            rdata = hi_q;
        end else if (MDU_op == OP_MFLO) begin
            rdata = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit (default parameters).
module tb_mdu_unit;

    localparam logic [3:0] OP_NONE  = 4'b0000;
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MFHI  = 4'b0101;
    localparam logic [3:0] OP_MFLO  = 4'b0110;
    localparam logic [3:0] OP_MTHI  = 4'b0111;
    localparam logic [3:0] OP_MTLO  = 4'b1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  MDU_op;
    logic [31:0] A1;
    logic [31:0] A2;
    logic        start;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;

    mdu_unit dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .MDU_op (MDU_op),
        .A1     (A1),
        .A2     (A2),
        .start  (start),
        .busy   (busy),
        .rdata  (rdata),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        en     = 1'b1;
        MDU_op = op;
        A1     = a;
        A2     = b;
        step();
        en     = 1'b0;
        MDU_op = OP_NONE;
    endtask

    // Counts busy cycles and notes whether HI/LO moved before the commit edge
    task automatic wait_busy(output int n, output bit held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0   = HI;
        l0   = LO;
        n    = 0;
        held = 1'b1;
        while (busy === 1'b1 && n < 100) begin
            if (HI !== h0 || LO !== l0) held = 1'b0;
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        en     = 1'b0;
        MDU_op = OP_MFHI;
        A1     = 32'd0;
        A2     = 32'd0;
        step();
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (HI !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", HI); end
        checks++; if (LO !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", LO); end
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", rdata); end
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start); end
        reset  = 1'b0;
        MDU_op = OP_NONE;
        step();
    endtask

    task automatic test_mult();
        int n;
        bit held;
        en = 1'b1; MDU_op = OP_MULT; A1 = 32'hFFFF_FFFF; A2 = 32'h0000_0002;
        #1;
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL mult_start got=%b exp=1", start); end
        step();
        en = 1'b0; MDU_op = OP_NONE;
        wait_busy(n, held);
        checks++; if (n !== 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL mult_early_commit got=%b exp=1", held); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
        checks++; if (LO !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffe", LO); end

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_busy(n, held);
        checks++; if (n !== 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
        checks++; if (HI !== 32'h0000_0001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", HI); end
        checks++; if (LO !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", LO); end

        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_busy(n, held);
        checks++; if ({HI, LO} !== 64'h4000_0000_0000_0000) begin failures++; $display("FAIL mult_minint got=%h exp=4000000000000000", {HI, LO}); end

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_busy(n, held);
        checks++; if ({HI, LO} !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL multu_max got=%h exp=fffffffe00000001", {HI, LO}); end
    endtask

    task automatic test_move();
        en = 1'b1; MDU_op = OP_MTHI; A1 = 32'hDEAD_BEEF; A2 = 32'd0;
        #1;
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL mthi_start got=%b exp=0", start); end
        step();
        MDU_op = OP_MFHI;
        #1;
        checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mfhi_rdata got=%h exp=deadbeef", rdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        MDU_op = OP_MTLO; A1 = 32'h1234_5678;
        step();
        MDU_op = OP_MFLO;
        #1;
        checks++; if (rdata !== 32'h1234_5678) begin failures++; $display("FAIL mflo_rdata got=%h exp=12345678", rdata); end
        checks++; if (HI !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mtlo_hi_kept got=%h exp=deadbeef", HI); end
        en = 1'b0; MDU_op = OP_MTHI; A1 = 32'h0BAD_F00D;
        step();
        checks++; if (HI !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mthi_en0 got=%h exp=deadbeef", HI); end
        MDU_op = OP_NONE;
        #1;
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL none_rdata got=%h exp=00000000", rdata); end
    endtask

    task automatic test_busy_ignore();
        issue(OP_MULT, 32'd3, 32'd4);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy_rise got=%b exp=1", busy); end
        en = 1'b1; MDU_op = OP_MULT; A1 = 32'd7; A2 = 32'd7;
        step();
        MDU_op = OP_MTLO; A1 = 32'hAAAA_AAAA;
        step();
        en = 1'b0; MDU_op = OP_NONE;
        step();
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy_last got=%b exp=1", busy); end
        en = 1'b1; MDU_op = OP_MULT; A1 = 32'd9; A2 = 32'd9;
        step();
        en = 1'b0; MDU_op = OP_NONE;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_busy_fall got=%b exp=0", busy); end
        checks++; if ({HI, LO} !== 64'd12) begin failures++; $display("FAIL ign_result got=%h exp=000000000000000c", {HI, LO}); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", busy); end
        checks++; if (LO !== 32'd12) begin failures++; $display("FAIL b2b_lo got=%h exp=0000000c", LO); end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        int n;
        bit held;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_busy(n, held);
        checks++; if (n !== 10) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL div_early_commit got=%b exp=1", held); end
        checks++; if (LO !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end

        issue(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE);
        wait_busy(n, held);
        checks++; if ({HI, LO} !== 64'h0000_0001_FFFF_FFFD) begin failures++; $display("FAIL div_negdvs got=%h exp=00000001fffffffd", {HI, LO}); end

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy(n, held);
        checks++; if ({HI, LO} !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL div_ovf got=%h exp=0000000080000000", {HI, LO}); end

        issue(OP_DIVU, 32'd100, 32'd7);
        wait_busy(n, held);
        checks++; if ({HI, LO} !== 64'h0000_0002_0000_000E) begin failures++; $display("FAIL divu got=%h exp=000000020000000e", {HI, LO}); end

        issue(OP_MTHI, 32'h11, 32'd0);
        issue(OP_MTLO, 32'h22, 32'd0);
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_busy(n, held);
        checks++; if (n !== 10) begin failures++; $display("FAIL div0_busy_cycles got=%0d exp=10", n); end
        checks++; if ({HI, LO} !== 64'h0000_0011_0000_0022) begin failures++; $display("FAIL div0_kept got=%h exp=0000001100000022", {HI, LO}); end
    endtask
`else
    task automatic test_div_disabled();
        issue(OP_MTHI, 32'h11, 32'd0);
        en = 1'b1; MDU_op = OP_DIV; A1 = 32'd9; A2 = 32'd2;
        #1;
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL nodiv_start got=%b exp=0", start); end
        step();
        MDU_op = OP_DIVU;
        step();
        en = 1'b0; MDU_op = OP_NONE;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nodiv_busy got=%b exp=0", busy); end
        checks++; if (HI !== 32'h11) begin failures++; $display("FAIL nodiv_hi got=%h exp=00000011", HI); end
        checks++; if (LO !== 32'd12) begin failures++; $display("FAIL nodiv_lo got=%h exp=0000000c", LO); end
    endtask
`endif

    task automatic test_reset_mid();
        issue(OP_MTHI, 32'h55, 32'd0);
`ifdef MDU_DIV_EN
        issue(OP_DIV, 32'd100, 32'd3);
`else
        issue(OP_MULT, 32'd100, 32'd3);
`endif
        step();
        step();
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if ({HI, LO} !== 64'd0) begin failures++; $display("FAIL rmid_hilo got=%h exp=0000000000000000", {HI, LO}); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy_after got=%b exp=0", busy); end
        checks++; if ({HI, LO} !== 64'd0) begin failures++; $display("FAIL rmid_no_commit got=%h exp=0000000000000000", {HI, LO}); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_move();
        test_busy_ignore();
`ifdef MDU_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
